// File: rtl/vc32_bus_responder_if.sv
// rtl/vc32_bus_responder_if.sv - multiplexed address/data bus between the CPU bridge and the responder
interface vc32_bus_responder_if;
  logic [7:0] bus_in;
  logic       latch_hi;
  logic       latch_lo;
  logic       write;
  logic       ind;
  logic [7:0] rdata_out;
  logic       interrupt;

  modport master (
    output bus_in, latch_hi, latch_lo, write, ind,
    input  rdata_out, interrupt
  );

  modport slave (
    input  bus_in, latch_hi, latch_lo, write, ind,
    output rdata_out, interrupt
  );
endinterface

// File: rtl/vc32_bus_responder.sv
// rtl/vc32_bus_responder.sv - byte memory responder on a multiplexed 16-bit bus
// with a memory-mapped interrupt control bit.
module vc32_bus_responder #(
  parameter int          MEM_BITS = 10,
  parameter logic [15:0] IRQ_ADDR = 16'hFFFF
) (
  input logic                  clk,
  input logic                  reset_in,
  vc32_bus_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HI, DATA, WR2} state_t;

  state_t     state_q;
  logic [7:0] a_hi_q;
  logic [6:0] a_lo_q;
  logic [7:0] dout_q;
  logic       irq_q;

  logic [7:0] mem [0:(1<<MEM_BITS)-1];

  logic [15:0] wr_addr;
  logic        wr_is_irq;
  logic        store_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;

  assign wr_addr   = {a_hi_q, a_lo_q, bus.ind};
  assign wr_is_irq = (wr_addr == IRQ_ADDR);
  // A new latch_hi aborts the cycle, so it also suppresses any pending store.
  assign store_en  = !reset_in && !bus.latch_hi && bus.write &&
                     ((state_q == DATA) || (state_q == WR2));

  always_comb begin
    rd_addr = {a_hi_q, a_lo_q, 1'b1};
    if (state_q == HI) begin
      rd_addr = {a_hi_q, bus.bus_in[7:1], bus.ind};
    end
  end

  always_comb begin
    rd_data = mem[rd_addr[MEM_BITS-1:0]];
    if (rd_addr == IRQ_ADDR) begin
      rd_data = {7'b0, irq_q};
    end else if (store_en && !wr_is_irq &&
                 (wr_addr[MEM_BITS-1:0] == rd_addr[MEM_BITS-1:0])) begin
      rd_data = bus.bus_in;
    end
  end

  always_ff @(posedge clk) begin
    if (store_en && !wr_is_irq) begin
      mem[wr_addr[MEM_BITS-1:0]] <= bus.bus_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q <= IDLE;
      a_hi_q  <= 8'h00;
      a_lo_q  <= 7'h00;
      dout_q  <= 8'h00;
      irq_q   <= 1'b0;
    end else if (bus.latch_hi) begin
      a_hi_q  <= bus.bus_in;
      state_q <= HI;
    end else begin
      case (state_q)
        IDLE: state_q <= IDLE;
        HI: begin
          if (bus.latch_lo) begin
            a_lo_q  <= bus.bus_in[7:1];
            dout_q  <= rd_data;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bus.write) begin
            if (wr_is_irq) begin
              irq_q <= bus.bus_in[0];
            end
            state_q <= WR2;
          end else begin
            dout_q  <= rd_data;
            state_q <= IDLE;
          end
        end
        WR2: begin
          if (bus.write && wr_is_irq) begin
            irq_q <= bus.bus_in[0];
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rdata_out = dout_q;
  assign bus.interrupt = irq_q;

endmodule

// File: doc/vc32_bus_responder.md
VC32_BUS_RESPONDER -- requirements
Module: vc32_bus_responder

Interface
REQ-001 SHALL have parameter MEM_BITS, default 10, giving byte-memory depth 2**MEM_BITS.
REQ-002 SHALL have parameter IRQ_ADDR, default 16'hFFFF, giving the byte address of the interrupt control register.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_in, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port bus_in, input, 8 bits: multiplexed address/data byte from the CPU bridge.
REQ-006 SHALL have port latch_hi, input, 1 bit: bus_in carries address [15:8].
REQ-007 SHALL have port latch_lo, input, 1 bit: bus_in[7:1] carries address [7:1].
REQ-008 SHALL have port write, input, 1 bit: bus_in carries a write data byte.
REQ-009 SHALL have port ind, input, 1 bit: byte-in-halfword select, giving address bit 0.
REQ-010 SHALL have port rdata_out, output, 8 bits: read data byte to the bridge, registered.
REQ-011 SHALL have port interrupt, output, 1 bit: interrupt request to the CPU, registered.

Function
REQ-012 SHALL implement FSM states IDLE, HI, DATA and WR2, plus registers a_hi[7:0], a_lo[6:0], dout[7:0] and irq.
REQ-013 latch_hi=1 in any state SHALL set a_hi<=bus_in and go to HI; this overrides every other transition (aborts a cycle in progress).
REQ-014 In HI with latch_lo=1, SHALL set a_lo<=bus_in[7:1] and dout<=mem[{bus_in[7:1],ind}] (address formed from live inputs, a_hi as upper byte), then go to DATA.
REQ-015 In HI with latch_lo=0, SHALL hold in HI.
REQ-016 Byte address A(b) SHALL be {a_hi,a_lo,b}; memory index SHALL be A[MEM_BITS-1:0], so upper bits alias (wrap) silently.
REQ-017 In DATA with write=1, SHALL store bus_in at A(ind) and go to WR2.
REQ-018 In DATA with write=0, SHALL set dout<=mem[A(1)] (second-byte prefetch) and go to IDLE; latency is one cycle per byte, each byte valid on rdata_out the edge after its request cycle.
REQ-019 In WR2 with write=1, SHALL store bus_in at A(ind); in WR2 SHALL go to IDLE regardless of write.
REQ-020 In IDLE and HI, write=1 without a preceding latch_lo SHALL be ignored.
REQ-021 A store whose full 16-bit A(ind) equals IRQ_ADDR SHALL set irq<=bus_in[0] and SHALL NOT modify memory.
REQ-022 A read whose full 16-bit address equals IRQ_ADDR SHALL return {7'b0,irq}.
REQ-023 rdata_out SHALL equal dout.
REQ-024 interrupt SHALL equal irq.
REQ-025 A read-after-write to the same address, within a single cycle, SHALL return the new data (write-first).
REQ-026 latch_lo and latch_hi asserted in the same cycle SHALL be treated as latch_hi only.

Reset
REQ-027 When reset_in=1 at a clock edge: state SHALL be IDLE, a_hi=0, a_lo=0, dout=0, irq=0, so rdata_out=0 and interrupt=0 from the next cycle.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset SHALL dominate all bus inputs, including mid-transaction; no store SHALL occur on a reset cycle.

Verification
REQ-030 16-bit write then read: latch_hi/0x12, latch_lo/0x34 ind=0, write/0xAA ind=0, write/0x55 ind=1; then the read sequence at 0x1234 -> rdata_out=0xAA one edge after the latch_lo cycle, 0x55 one edge later.
REQ-031 Byte write: latch_hi/0x00, latch_lo/0x10 ind=1, write/0x7E ind=1, idle; then read at 0x0011 with ind=1 -> first byte 0x7E; byte 0x0010 unchanged.
REQ-032 Interrupt register: write 0x01 to 0xFFFF -> interrupt=1 next cycle, memory index 0x3FF unchanged; read 0xFFFF -> 0x01; write 0x00 -> interrupt=0.
REQ-033 Abort: latch_hi/0x12, latch_lo/0x34, then latch_hi/0x56 instead of write -> FSM in HI, no store at 0x1234.
REQ-034 Wrap: with MEM_BITS=10, write 0x99 to 0x0400 -> read of 0x0000 returns 0x99.
REQ-035 Reset mid-write: reset_in=1 during the DATA cycle with write=1 -> no store, rdata_out=0, interrupt=0, FSM in IDLE.
